fetch_unit: RTL

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/riscv_pkg.sv | 20 ++
 rtl/fetch_skid_buf.sv | 88 ++++++++
 rtl/fetch_unit.sv | 112 +++++++++++
 3 files changed

// File: rtl/riscv_pkg.sv
// Shared fetch-stage types and constants: widths, fetch FSM states and PC helpers.
// No logic of its own; imported by the fetch unit and its skid buffer.
package riscv_pkg;

    localparam int XLEN = 64;
    localparam int ILEN = 32;
    localparam logic [XLEN-1:0] PC_STEP = 64'd4;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        WAIT,
        DRAIN
    } fetch_state_t;

    function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] addr);
        return {addr[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_skid_buf.sv
// IF/ID output register plus one skid entry; a delivery is visible one cycle later.
// A stalled output parks the next word in the skid; flush empties both entries.
module fetch_skid_buf
    import riscv_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic            deliver,
    input  logic            stall,
    input  logic            flush,
    input  logic [ILEN-1:0] in_instr,
    input  logic [XLEN-1:0] in_pc,
    output logic            valid_out,
    output logic [ILEN-1:0] instr_out,
    output logic [XLEN-1:0] pc_out,
    output logic            skid_valid
);

    logic            valid_q, valid_d;
    logic [ILEN-1:0] instr_q, instr_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic            skid_valid_q, skid_valid_d;
    logic [ILEN-1:0] skid_instr_q, skid_instr_d;
    logic [XLEN-1:0] skid_pc_q, skid_pc_d;
    logic            consume;

    assign consume = valid_q && !stall;

    always_comb begin
        valid_d      = valid_q;
        instr_d      = instr_q;
        pc_d         = pc_q;
        skid_valid_d = skid_valid_q;
        skid_instr_d = skid_instr_q;
        skid_pc_d    = skid_pc_q;
        if (flush) begin
            valid_d      = 1'b0;
            skid_valid_d = 1'b0;
        end else begin
            if (consume) begin
                if (skid_valid_q) begin
                    valid_d      = 1'b1;
                    instr_d      = skid_instr_q;
                    pc_d         = skid_pc_q;
                    skid_valid_d = 1'b0;
                end else begin
                    valid_d = 1'b0;
                end
            end
            if (deliver) begin
                // The skid keeps program order if it is draining into the output this cycle.
                if ((!valid_q || !stall) && !(consume && skid_valid_q)) begin
                    valid_d = 1'b1;
                    instr_d = in_instr;
                    pc_d    = in_pc;
                end else begin
                    skid_valid_d = 1'b1;
                    skid_instr_d = in_instr;
                    skid_pc_d    = in_pc;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q      <= 1'b0;
            instr_q      <= '0;
            pc_q         <= '0;
            skid_valid_q <= 1'b0;
            skid_instr_q <= '0;
            skid_pc_q    <= '0;
        end else begin
            valid_q      <= valid_d;
            instr_q      <= instr_d;
            pc_q         <= pc_d;
            skid_valid_q <= skid_valid_d;
            skid_instr_q <= skid_instr_d;
            skid_pc_q    <= skid_pc_d;
        end
    end

    assign valid_out  = valid_q;
    assign instr_out  = instr_q;
    assign pc_out     = pc_q;
    assign skid_valid = skid_valid_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: issues word requests, holds them until ready, feeds IF/ID one cycle later.
// Stall backs up into a one-entry skid and then blocks new requests; branch flushes and redirects.
module fetch_unit
    import riscv_pkg::*;
#(
    parameter logic [63:0] RESET_PC = 64'h0
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [63:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [63:0] branch_target,
    output logic [31:0] instr_out,
    output logic [63:0] pc_out,
    output logic        valid_out
);

    fetch_state_t    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] req_addr_q, req_addr_d;
    logic            deliver;
    logic            flush;
    logic            skid_valid;

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        req_addr_d = req_addr_q;
        imem_req   = 1'b0;
        imem_addr  = req_addr_q;
        deliver    = 1'b0;
        flush      = 1'b0;
        unique case (state_q)
            IDLE: begin
                state_d = FETCH;
            end
            FETCH: begin
                if (branch_taken) begin
                    flush = 1'b1;
                    pc_d  = align_pc(branch_target);
                end else if (!skid_valid) begin
                    imem_req   = 1'b1;
                    imem_addr  = pc_q;
                    req_addr_d = pc_q;
                    if (imem_ready) begin
                        deliver = 1'b1;
                        pc_d    = pc_q + PC_STEP;
                    end else begin
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                imem_req = 1'b1;
                if (branch_taken) begin
                    flush   = 1'b1;
                    pc_d    = align_pc(branch_target);
                    state_d = imem_ready ? FETCH : DRAIN;
                end else if (imem_ready) begin
                    deliver = 1'b1;
                    pc_d    = pc_q + PC_STEP;
                    state_d = FETCH;
                end
            end
            DRAIN: begin
                // Wrong-path request still in flight: keep it asserted, throw its data away.
                imem_req = 1'b1;
                if (branch_taken) begin
                    flush = 1'b1;
                    pc_d  = align_pc(branch_target);
                end
                if (imem_ready) begin
                    state_d = FETCH;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            pc_q       <= RESET_PC;
            req_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            req_addr_q <= req_addr_d;
        end
    end

    fetch_skid_buf u_skid (
        .clk        (clk),
        .reset      (reset),
        .deliver    (deliver),
        .stall      (stall),
        .flush      (flush),
        .in_instr   (imem_rdata),
        .in_pc      (imem_addr),
        .valid_out  (valid_out),
        .instr_out  (instr_out),
        .pc_out     (pc_out),
        .skid_valid (skid_valid)
    );

endmodule
